// File: rtl/bsearch_pkg.sv
// ---------------------------------------------------------------------------
// bsearch_pkg
//   Shared definitions for the binary-search engine.
//   - state_t    : search FSM states
//   - calc_prb_w : width of the probe counter for a given address width.
//                  A search over at most 2**ADDR_W entries needs at most
//                  ADDR_W+1 probes, so the counter must hold 0..ADDR_W+1.
// ---------------------------------------------------------------------------
package bsearch_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PROBE = 3'd1,
      WAIT  = 3'd2,
      CMP   = 3'd3,
      DONE  = 3'd4
   } state_t;

   function automatic int calc_prb_w(input int addr_w);
      return $clog2(addr_w + 2);
   endfunction

endpackage

// File: rtl/bsearch_lat_cnt.sv
// ---------------------------------------------------------------------------
// bsearch_lat_cnt
//   Counts the extra cycles the engine must sit in WAIT while a RAM read with
//   latency RD_LAT (>= 2) is in flight. The engine spends one cycle in PROBE
//   and one in CMP, so WAIT covers the remaining RD_LAT-1 cycles.
//
//   Ports
//     clk   in   clock, rising edge
//     clr   in   asynchronous reset, active-low
//     run   in   high while the engine is in WAIT
//     last  out  high in the final WAIT cycle (engine moves to CMP next)
// ---------------------------------------------------------------------------
module bsearch_lat_cnt #(
   parameter int RD_LAT = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic run,
   output logic last
);

   localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

   logic [CNT_W-1:0] cnt;

   // The counter restarts from zero whenever the engine is outside WAIT, so
   // every probe sees a fresh count without an explicit load pulse.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt <= '0;
      end else if (run && !last) begin
         cnt <= cnt + CNT_W'(1);
      end else begin
         cnt <= '0;
      end
   end

   assign last = (cnt == CNT_W'(RD_LAT - 2));

endmodule

// File: rtl/bsearch_engine.sv
// ---------------------------------------------------------------------------
// bsearch_engine
//   Binary search over a sorted ascending array held in an external RAM with
//   synchronous read of latency RD_LAT. Returns whether the key is present,
//   the matching index (or the insertion point when absent) and the number
//   of RAM reads used.
//
//   Parameters
//     DATA_W  key / word width (unsigned compare)
//     ADDR_W  RAM address width
//     DEPTH   number of valid entries, 1..2**ADDR_W
//     RD_LAT  RAM read latency in cycles, >= 1
//
//   Ports
//     clk       in   clock, rising edge
//     clr       in   asynchronous reset, active-low
//     start     in   search request, sampled only while idle
//     key       in   search key, latched when start is accepted
//     mode      in   (BSEARCH_LBOUND_EN only) 1 = lower-bound search
//     mem_addr  out  RAM read address (holds its value between reads)
//     mem_rd    out  RAM read strobe
//     mem_q     in   RAM data, valid RD_LAT cycles after mem_rd
//     busy      out  search in progress
//     done      out  one-cycle pulse, results valid
//     found     out  key present
//     idx       out  match index, else insertion point (0..DEPTH)
//     probes    out  number of RAM reads used
//
//   Build option
//     BSEARCH_LBOUND_EN  adds the mode port and lower-bound search. Without
//                        it the engine performs exact search only.
// ---------------------------------------------------------------------------
module bsearch_engine
   import bsearch_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32,
   parameter int RD_LAT = 1
) (
   input  logic                            clk,
   input  logic                            clr,
   input  logic                            start,
   input  logic [DATA_W-1:0]               key,
`ifdef BSEARCH_LBOUND_EN
   input  logic                            mode,
`endif
   output logic [ADDR_W-1:0]               mem_addr,
   output logic                            mem_rd,
   input  logic [DATA_W-1:0]               mem_q,
   output logic                            busy,
   output logic                            done,
   output logic                            found,
   output logic [ADDR_W:0]                 idx,
   output logic [calc_prb_w(ADDR_W)-1:0]   probes
);

   localparam int PRB_W = calc_prb_w(ADDR_W);

   localparam logic [ADDR_W:0]   DEPTH_HI = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] INIT_MID = ADDR_W'(DEPTH / 2);

   state_t             state;
   logic [DATA_W-1:0]  key_q;
   logic [ADDR_W:0]    lo;
   logic [ADDR_W:0]    hi;
   logic               hit_q;
   logic               lb_mode;
   logic               wait_last;

   logic [ADDR_W:0]    mid_ext;
   logic [ADDR_W:0]    lo_nxt;
   logic [ADDR_W:0]    hi_nxt;
   logic [ADDR_W+1:0]  sum_nxt;
   logic [ADDR_W-1:0]  mid_nxt;
   logic               rd_nxt;
   logic               cmp_eq;
   logic               cmp_lt;
   logic               early_hit;

`ifdef BSEARCH_LBOUND_EN
   logic               mode_q;

   // The search mode is captured together with the key so that a change on
   // the mode pin mid-search cannot corrupt the running search.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         mode_q <= 1'b0;
      end else if (state == IDLE && start) begin
         mode_q <= mode;
      end
   end

   assign lb_mode = mode_q;
`else
   assign lb_mode = 1'b0;
`endif

   // Latency longer than one cycle needs a WAIT counter; with a single-cycle
   // RAM the FSM never enters WAIT, so no counter is built.
   generate
      if (RD_LAT > 1) begin : g_lat
         bsearch_lat_cnt #(
            .RD_LAT (RD_LAT)
         ) u_lat_cnt (
            .clk  (clk),
            .clr  (clr),
            .run  (state == WAIT),
            .last (wait_last)
         );
      end else begin : g_no_lat
         assign wait_last = 1'b1;
      end
   endgenerate

   // Next-interval computation used in CMP. The read for the following probe
   // is issued on the same edge that leaves CMP, so the RAM address is
   // already on the bus during PROBE; this keeps each probe at RD_LAT+1
   // cycles. mem_addr doubles as the current mid. The sum is one bit wider
   // than lo/hi so it cannot overflow.
   always_comb begin
      mid_ext   = {1'b0, mem_addr};
      cmp_eq    = (mem_q == key_q);
      cmp_lt    = (mem_q < key_q);
      early_hit = cmp_eq && !lb_mode;
      lo_nxt    = lo;
      hi_nxt    = hi;
      if (cmp_lt) begin
         lo_nxt = mid_ext + (ADDR_W+1)'(1);
      end else begin
         hi_nxt = mid_ext;
      end
      sum_nxt = {1'b0, lo_nxt} + {1'b0, hi_nxt};
      mid_nxt = ADDR_W'(sum_nxt >> 1);
      rd_nxt  = (lo_nxt < hi_nxt);
   end

   // Search FSM with registered outputs. done and mem_rd default low every
   // cycle so that each is a single-cycle pulse. Results (found/idx/probes)
   // stay put after DONE until the next accepted start.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= IDLE;
         key_q    <= '0;
         lo       <= '0;
         hi       <= '0;
         hit_q    <= 1'b0;
         mem_addr <= '0;
         mem_rd   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         found    <= 1'b0;
         idx      <= '0;
         probes   <= '0;
      end else begin
         done   <= 1'b0;
         mem_rd <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  key_q    <= key;
                  lo       <= '0;
                  hi       <= DEPTH_HI;
                  hit_q    <= 1'b0;
                  mem_addr <= INIT_MID;
                  mem_rd   <= 1'b1;
                  busy     <= 1'b1;
                  found    <= 1'b0;
                  idx      <= '0;
                  probes   <= '0;
                  state    <= PROBE;
               end
            end

            // An empty interval ends the search; otherwise the read that was
            // put on the bus when entering PROBE is counted here.
            PROBE: begin
               if (lo >= hi) begin
                  found <= hit_q;
                  idx   <= lo;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  probes <= probes + PRB_W'(1);
                  state  <= (RD_LAT > 1) ? WAIT : CMP;
               end
            end

            WAIT: begin
               if (wait_last) begin
                  state <= CMP;
               end
            end

            // Exact search stops on the first equal word. Lower-bound search
            // keeps narrowing towards the first word >= key and only records
            // that an equal word was seen.
            CMP: begin
               if (early_hit) begin
                  found <= 1'b1;
                  idx   <= mid_ext;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  lo <= lo_nxt;
                  hi <= hi_nxt;
                  if (cmp_eq) begin
                     hit_q <= 1'b1;
                  end
                  if (rd_nxt) begin
                     mem_addr <= mid_nxt;
                  end
                  mem_rd <= rd_nxt;
                  state  <= PROBE;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bsearch_engine.sv
// ---------------------------------------------------------------------------
// tb_bsearch_engine
//   Directed bench for bsearch_engine. Two engines share clock, reset, start
//   and key: dut_a with a single-cycle RAM and dut_b with a three-cycle RAM.
//   Both read the same RAM image (word i = 2*i by default). Timing is counted
//   from the edge after which start is raised: cycles=N means done is seen
//   just after the N-th following rising edge.
// ---------------------------------------------------------------------------
module tb_bsearch_engine;

   logic       clk;
   logic       clr;
   logic       start;
   logic [7:0] key;
`ifdef BSEARCH_LBOUND_EN
   logic       mode;
`endif

   logic [4:0] mem_addr_a, mem_addr_b;
   logic       mem_rd_a,   mem_rd_b;
   logic [7:0] mem_q_a,    mem_q_b;
   logic       busy_a,     busy_b;
   logic       done_a,     done_b;
   logic       found_a,    found_b;
   logic [5:0] idx_a,      idx_b;
   logic [2:0] probes_a,   probes_b;

   logic [7:0] ram [0:31];
   logic [7:0] pipe_a;
   logic [7:0] pipe_b [0:2];

   int errors;
   int checks;

   bsearch_engine #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RD_LAT(1)) dut_a (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .key      (key),
`ifdef BSEARCH_LBOUND_EN
      .mode     (mode),
`endif
      .mem_addr (mem_addr_a),
      .mem_rd   (mem_rd_a),
      .mem_q    (mem_q_a),
      .busy     (busy_a),
      .done     (done_a),
      .found    (found_a),
      .idx      (idx_a),
      .probes   (probes_a)
   );

   bsearch_engine #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RD_LAT(3)) dut_b (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .key      (key),
`ifdef BSEARCH_LBOUND_EN
      .mode     (mode),
`endif
      .mem_addr (mem_addr_b),
      .mem_rd   (mem_rd_b),
      .mem_q    (mem_q_b),
      .busy     (busy_b),
      .done     (done_b),
      .found    (found_b),
      .idx      (idx_b),
      .probes   (probes_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models: data only appears for cycles where a read was strobed;
   // otherwise a junk word is returned so a missing strobe is visible.
   always @(posedge clk) begin
      pipe_a <= mem_rd_a ? ram[mem_addr_a] : 8'hA5;
   end
   assign mem_q_a = pipe_a;

   always @(posedge clk) begin
      pipe_b[0] <= mem_rd_b ? ram[mem_addr_b] : 8'hA5;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign mem_q_b = pipe_b[2];

   task automatic load_ram_linear();
      for (int i = 0; i < 32; i++) ram[i] = 8'(2 * i);
   endtask

   // Raises start for one cycle with key k, then waits (bounded) for done on
   // the selected engine. Returns the cycle count and the number of cycles
   // mem_rd was seen high.
   task automatic run_search(input bit use_b, input logic [7:0] k,
                             output int cycles, output int rd_pulses);
      @(posedge clk); #1;
      start = 1'b1;
      key   = k;
      @(posedge clk); #1;
      start = 1'b0;
      cycles    = 1;
      rd_pulses = 0;
      while ((use_b ? done_b : done_a) !== 1'b1 && cycles < 200) begin
         if ((use_b ? mem_rd_b : mem_rd_a) === 1'b1) rd_pulses++;
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic test_reset();
      #3 clr = 1'b0;
      #10;
      checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_a); end
      checks++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done_a); end
      checks++; if (found_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_found: got %b want 0", found_a); end
      checks++; if (idx_a !== 6'd0) begin errors++; $display("[TB] FAIL reset_idx: got %0d want 0", idx_a); end
      checks++; if (probes_a !== 3'd0) begin errors++; $display("[TB] FAIL reset_probes: got %0d want 0", probes_a); end
      checks++; if (mem_rd_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_rd: got %b want 0", mem_rd_a); end
      checks++; if (mem_addr_a !== 5'd0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %0d want 0", mem_addr_a); end
      @(negedge clk);
      clr = 1'b1;
   endtask

   task automatic test_exact_hits();
      int keys [4];
      int e_idx [4];
      int e_prb [4];
      int e_cyc [4];
      int cyc, rdp;
      keys  = '{32, 20, 0, 62};
      e_idx = '{16, 10, 0, 31};
      e_prb = '{1, 4, 6, 5};
      e_cyc = '{3, 9, 13, 11};
      for (int i = 0; i < 4; i++) begin
         run_search(1'b0, 8'(keys[i]), cyc, rdp);
         checks++; if (cyc !== e_cyc[i]) begin errors++; $display("[TB] FAIL hit%0d_cycles: got %0d want %0d", keys[i], cyc, e_cyc[i]); end
         checks++; if (found_a !== 1'b1) begin errors++; $display("[TB] FAIL hit%0d_found: got %b want 1", keys[i], found_a); end
         checks++; if (int'(idx_a) !== e_idx[i]) begin errors++; $display("[TB] FAIL hit%0d_idx: got %0d want %0d", keys[i], idx_a, e_idx[i]); end
         checks++; if (int'(probes_a) !== e_prb[i]) begin errors++; $display("[TB] FAIL hit%0d_probes: got %0d want %0d", keys[i], probes_a, e_prb[i]); end
         checks++; if (rdp !== e_prb[i]) begin errors++; $display("[TB] FAIL hit%0d_rd_strobes: got %0d want %0d", keys[i], rdp, e_prb[i]); end
      end
   endtask

   task automatic test_misses();
      int keys [2];
      int e_idx [2];
      int e_addr [2];
      int cyc, rdp;
      keys   = '{21, 63};
      e_idx  = '{11, 32};
      e_addr = '{11, 31};
      for (int i = 0; i < 2; i++) begin
         run_search(1'b0, 8'(keys[i]), cyc, rdp);
         checks++; if (cyc !== 12) begin errors++; $display("[TB] FAIL miss%0d_cycles: got %0d want 12", keys[i], cyc); end
         checks++; if (found_a !== 1'b0) begin errors++; $display("[TB] FAIL miss%0d_found: got %b want 0", keys[i], found_a); end
         checks++; if (int'(idx_a) !== e_idx[i]) begin errors++; $display("[TB] FAIL miss%0d_idx: got %0d want %0d", keys[i], idx_a, e_idx[i]); end
         checks++; if (probes_a !== 3'd5) begin errors++; $display("[TB] FAIL miss%0d_probes: got %0d want 5", keys[i], probes_a); end
         checks++; if (rdp !== 5) begin errors++; $display("[TB] FAIL miss%0d_rd_strobes: got %0d want 5", keys[i], rdp); end
         checks++; if (int'(mem_addr_a) !== e_addr[i] || mem_rd_a !== 1'b0) begin errors++; $display("[TB] FAIL miss%0d_addr_hold: got addr %0d rd %b want addr %0d rd 0", keys[i], mem_addr_a, mem_rd_a, e_addr[i]); end
         @(posedge clk); #1;
         checks++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL miss%0d_done_pulse: got %b want 0", keys[i], done_a); end
         repeat (3) @(posedge clk);
         #1;
         checks++; if (found_a !== 1'b0 || int'(idx_a) !== e_idx[i]) begin errors++; $display("[TB] FAIL miss%0d_held: got found %b idx %0d want 0/%0d", keys[i], found_a, idx_a, e_idx[i]); end
      end
   endtask

   task automatic test_busy_ignore();
      int   pulses;
      int   r_idx;
      logic r_found;
      logic [2:0] r_probes;
      @(posedge clk); #1;
      start = 1'b1;
      key   = 8'd20;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      key   = 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
      pulses   = 0;
      r_idx    = -1;
      r_found  = 1'b0;
      r_probes = '0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done_a === 1'b1) begin
            pulses++;
            r_idx    = int'(idx_a);
            r_found  = found_a;
            r_probes = probes_a;
         end
      end
      checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL busy_ignore_pulses: got %0d want 1", pulses); end
      checks++; if (r_found !== 1'b1) begin errors++; $display("[TB] FAIL busy_ignore_found: got %b want 1", r_found); end
      checks++; if (r_idx !== 10) begin errors++; $display("[TB] FAIL busy_ignore_idx: got %0d want 10", r_idx); end
      checks++; if (r_probes !== 3'd4) begin errors++; $display("[TB] FAIL busy_ignore_probes: got %0d want 4", r_probes); end
   endtask

   task automatic test_back_to_back();
      int cyc, rdp;
      run_search(1'b0, 8'd62, cyc, rdp);
      checks++; if (done_a !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_done: got %b want 1", done_a); end
      start = 1'b1;
      key   = 8'd32;
      @(posedge clk); #1;
      checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_cycle_start: got busy %b want 0", busy_a); end
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL b2b_next_cycle_start: got busy %b want 1", busy_a); end
      cyc = 0;
      while (done_a !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (cyc !== 2) begin errors++; $display("[TB] FAIL b2b_latency: got %0d want 2", cyc); end
      checks++; if (found_a !== 1'b1 || idx_a !== 6'd16) begin errors++; $display("[TB] FAIL b2b_result: got found %b idx %0d want 1/16", found_a, idx_a); end
   endtask

   task automatic test_abort();
      int pulses, cyc, rdp;
      @(posedge clk); #1;
      start = 1'b1;
      key   = 8'd62;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (busy_a !== 1'b1 || probes_a === 3'd0) begin errors++; $display("[TB] FAIL abort_in_flight: got busy %b probes %0d want 1/nonzero", busy_a, probes_a); end
      #4 clr = 1'b0;
      #1;
      checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("[TB] FAIL abort_ctrl: got busy %b done %b want 0/0", busy_a, done_a); end
      checks++; if (found_a !== 1'b0 || idx_a !== 6'd0 || probes_a !== 3'd0) begin errors++; $display("[TB] FAIL abort_results: got found %b idx %0d probes %0d want 0/0/0", found_a, idx_a, probes_a); end
      @(posedge clk);
      #5 clr = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done_a === 1'b1) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d pulses want 0", pulses); end
      run_search(1'b0, 8'd20, cyc, rdp);
      checks++; if (cyc !== 9) begin errors++; $display("[TB] FAIL abort_restart_cycles: got %0d want 9", cyc); end
      checks++; if (found_a !== 1'b1 || idx_a !== 6'd10 || probes_a !== 3'd4) begin errors++; $display("[TB] FAIL abort_restart_result: got found %b idx %0d probes %0d want 1/10/4", found_a, idx_a, probes_a); end
   endtask

   task automatic test_latency();
      int cyc, rdp;
      repeat (40) @(posedge clk);
      run_search(1'b1, 8'd21, cyc, rdp);
      checks++; if (cyc !== 22) begin errors++; $display("[TB] FAIL lat3_miss_cycles: got %0d want 22", cyc); end
      checks++; if (found_b !== 1'b0 || idx_b !== 6'd11) begin errors++; $display("[TB] FAIL lat3_miss_result: got found %b idx %0d want 0/11", found_b, idx_b); end
      checks++; if (probes_b !== 3'd5 || rdp !== 5) begin errors++; $display("[TB] FAIL lat3_miss_probes: got probes %0d strobes %0d want 5/5", probes_b, rdp); end
      repeat (40) @(posedge clk);
      run_search(1'b1, 8'd32, cyc, rdp);
      checks++; if (cyc !== 5) begin errors++; $display("[TB] FAIL lat3_hit_cycles: got %0d want 5", cyc); end
      checks++; if (found_b !== 1'b1 || idx_b !== 6'd16) begin errors++; $display("[TB] FAIL lat3_hit_result: got found %b idx %0d want 1/16", found_b, idx_b); end
   endtask

`ifdef BSEARCH_LBOUND_EN
   task automatic test_lower_bound();
      int cyc, rdp;
      repeat (40) @(posedge clk);
      ram[0] = 8'd1;
      for (int i = 1; i < 4; i++) ram[i] = 8'd3;
      for (int i = 4; i < 32; i++) ram[i] = 8'(2 * i - 3);
      mode = 1'b1;
      run_search(1'b0, 8'd3, cyc, rdp);
      checks++; if (cyc !== 14) begin errors++; $display("[TB] FAIL lb3_cycles: got %0d want 14", cyc); end
      checks++; if (found_a !== 1'b1 || idx_a !== 6'd1) begin errors++; $display("[TB] FAIL lb3_result: got found %b idx %0d want 1/1", found_a, idx_a); end
      checks++; if (probes_a !== 3'd6) begin errors++; $display("[TB] FAIL lb3_probes: got %0d want 6", probes_a); end
      run_search(1'b0, 8'd4, cyc, rdp);
      checks++; if (found_a !== 1'b0 || idx_a !== 6'd4) begin errors++; $display("[TB] FAIL lb4_result: got found %b idx %0d want 0/4", found_a, idx_a); end
      checks++; if (probes_a !== 3'd5) begin errors++; $display("[TB] FAIL lb4_probes: got %0d want 5", probes_a); end
      mode = 1'b0;
      run_search(1'b0, 8'd3, cyc, rdp);
      checks++; if (found_a !== 1'b1 || idx_a !== 6'd2) begin errors++; $display("[TB] FAIL exact3_result: got found %b idx %0d want 1/2", found_a, idx_a); end
      checks++; if (cyc !== 9) begin errors++; $display("[TB] FAIL exact3_cycles: got %0d want 9", cyc); end
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      clr    = 1'b1;
      start  = 1'b0;
      key    = 8'd0;
`ifdef BSEARCH_LBOUND_EN
      mode   = 1'b0;
`endif
      load_ram_linear();
      $display("[TB] starting bsearch_engine bench");
      test_reset();
      test_exact_hits();
      test_misses();
      test_busy_ignore();
      test_back_to_back();
      test_abort();
      test_latency();
`ifdef BSEARCH_LBOUND_EN
      test_lower_bound();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
